bcd_mult11_gen: RTL and testbench
=================================

// Module: bcd_mult11_gen
// PURPOSE
//  Sequential producer of 4-digit packed-BCD multiples of 11: 0000, 0011, 0022, ... 9999, 0000, ...
//  Emits one value per valid/ready handshake for a programmed beat count, or free-runs.
//  Drives the stimulus side of the mult_11 divisibility checker.
//  Also serves as the BCD source for the lab datapath self-check.
// PARAMETERS
//  DIGITS    4        BCD digits in out_bcd; out_bcd width is 4*DIGITS.
//  STEP_BCD  16'h0011 Packed-BCD increment per beat; every nibble must be 0-9.
//  CNT_W     10       Width of count_in; must hold 910, one full period at STEP 11.
// PORTS
//  clk        in   1         Rising-edge clock.
//  rst_n      in   1         Asynchronous, active-low reset.
//  start      in   1         Begin a run; sampled in IDLE only.
//  count_in   in   CNT_W     Beats to emit; 0 = free-run until abort.
//  abort      in   1         Terminate the current run.
//  out_bcd    out  4*DIGITS  Current packed-BCD value; MS digit in [15:12].
//  out_valid  out  1         out_bcd is valid.
//  out_ready  in   1         Consumer accepts out_bcd this cycle.
//  busy       out  1         state != IDLE.
//  done       out  1         One-cycle pulse after the final beat of a counted run.
//  wrap       out  1         One-cycle pulse on the cycle 0000 is first presented after a wrap.
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, out_bcd=0, out_valid=0, busy=0, done=0, wrap=0, remaining=0.
//   - Takes effect immediately, including mid-run; no partial beat survives.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE & start: load out_bcd=0, remaining=count_in, go to RUN.
//   - out_valid=1 on the next cycle, giving 1-cycle start-to-first-beat latency.
//   - RUN beat: a beat is out_valid & out_ready.
//     - If remaining==1, go to DONE; out_valid=0 next cycle.
//     - Otherwise advance out_bcd and decrement remaining, except when remaining==0 (free-run: no decrement).
//   - RUN stall: when out_ready=0, out_bcd, out_valid and remaining hold; out_valid never drops without a beat, except on abort or reset.
//   - DONE: done=1 for exactly one cycle, then IDLE. busy=1 in RUN and DONE.
//  Advance:
//   - next = out_bcd + STEP_BCD, digit-serial BCD add, LS digit first.
//   - Per digit: sum = a+b+cin; if sum>9 then add 6, take the low nibble and set cout=1.
//   - If the top digit carries out, next = 0 and wrap=1 in the cycle 0000 is presented. Example: 9999 -> 0000.
//   - With STEP 11 the period is 910 beats, and every emitted value is a multiple of 11.
//  Boundaries:
//   - start while busy is ignored.
//   - abort in RUN or DONE: IDLE next cycle, out_valid=0, no done pulse.
//   - A beat completing in the same cycle as abort counts as delivered; no further beats follow.
//   - start & abort together in IDLE: abort wins and the run does not start.
//   - count_in=1: single beat 0000, then done.
//   - count_in > 910 with STEP 11: the sequence wraps and continues; wrap pulses on each wrap.
//  out_bcd holds its last value in IDLE; it is don't-care to the consumer while out_valid=0.
// STRUCTURE
//  Shared package bcd_pkg:
//   - BCD_DIGIT_W=4 and BCD_MAX_DIGIT=9.
//   - State encoding localparams IDLE/RUN/DONE.
//   - Default STEP_BCD.
//  Sub-module bcd_digit_add: a, b [3:0], cin -> sum [3:0], cout. Combinational, with +6 correction.
//   - Instantiated DIGITS times in a carry chain.
//   - Top cout feeds the wrap logic.
//  Top level: FSM, remaining counter, out_bcd register, and done/wrap pulse registers.
// TESTING
//  1 Reset: rst_n=0 with no clock -> out_valid=0, out_bcd=0000, busy=0, done=0, wrap=0.
//  2 Counted run: start, count_in=4, out_ready=1.
//    -> Beats 0000, 0011, 0022, 0033 on consecutive cycles.
//    -> done=1 one cycle after the 0033 beat; busy=0 the cycle after that.
//  3 Backpressure: out_ready=0 for 3 cycles while 0022 is presented.
//    -> out_bcd=0022 and out_valid=1 held; next beat is 0033; total beats still 4.
//  4 Digit carry/wrap: free-run, checking each beat with mult_11 (out=1).
//    -> Sequence 0088, 0099, 0110 around the digit carry.
//    -> Beat 910 is 9999, beat 911 is 0000 with wrap=1 for one cycle.
//  5 Abort: abort while 0055 is presented and out_ready=0.
//    -> out_valid=0 next cycle, no done, busy=0; start asserted during RUN is ignored.
//  6 Mid-run reset: rst_n low at beat 0044 between clock edges.
//    -> All outputs take reset values immediately; the next start restarts at 0000.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit limits, default step and FSM encoding for the
// multiples-of-11 generator.
package bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX_DIGIT = 9;
  localparam logic [15:0] DEF_STEP_BCD = 16'h0011;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: one packed-BCD digit adder with +6 decimal correction.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  input  logic [BCD_DIGIT_W-1:0] b,
  input  logic                   cin,
  output logic [BCD_DIGIT_W-1:0] sum,
  output logic                   cout
);
  logic [BCD_DIGIT_W:0] raw;
  assign raw  = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
  assign cout = raw > (BCD_DIGIT_W+1)'(BCD_MAX_DIGIT);
  assign sum  = cout ? raw[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(6) : raw[BCD_DIGIT_W-1:0];
endmodule

// File: rtl/bcd_mult11_gen.sv
// bcd_mult11_gen: valid/ready producer of packed-BCD multiples of STEP_BCD,
// counted or free-running, with done and wrap pulses.
module bcd_mult11_gen
  import bcd_pkg::*;
#(
  parameter int                          DIGITS   = 4,
  parameter logic [BCD_DIGIT_W*DIGITS-1:0] STEP_BCD = (BCD_DIGIT_W*DIGITS)'(DEF_STEP_BCD),
  parameter int                          CNT_W    = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [CNT_W-1:0]              count_in,
  input  logic                          abort,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          wrap
);
  localparam int W = BCD_DIGIT_W * DIGITS;
  state_t           state_q, state_d;
  logic [W-1:0]     bcd_q, bcd_d, bcd_nxt;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             wrap_q, wrap_d;
  logic [DIGITS:0]  c;
  assign c[0] = 1'b0;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_add u_add (
      .a   (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .b   (STEP_BCD[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .cin (c[g]),
      .sum (bcd_nxt[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .cout(c[g+1])
    );
  end
  // A carry out of the top digit restarts the sequence at zero rather than
  // keeping the truncated low digits.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    rem_d   = rem_q;
    wrap_d  = 1'b0;
    if (abort) state_d = IDLE;
    else
      case (state_q)
        IDLE: if (start) begin
          state_d = RUN;
          bcd_d   = '0;
          rem_d   = count_in;
        end
        RUN: if (out_ready) begin
          if (rem_q == CNT_W'(1)) state_d = DONE;
          else begin
            bcd_d  = c[DIGITS] ? '0 : bcd_nxt;
            wrap_d = c[DIGITS];
            rem_d  = (rem_q == '0) ? rem_q : rem_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
    end
  assign out_bcd   = bcd_q;
  assign out_valid = state_q == RUN;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign wrap      = wrap_q;
endmodule

// File: tb/tb_bcd_mult11_gen.sv
// tb_bcd_mult11_gen: scoreboard bench; stimulus queues decimal-model beats,
// a negedge monitor compares every presented value and wrap pulse.
module tb_bcd_mult11_gen;
  typedef struct {logic [15:0] bcd; logic wrap;} item_t;
  logic        clk = 0, rst_n = 0, start = 0, abort = 0, out_ready = 0;
  logic [9:0]  count_in = '0;
  logic [15:0] out_bcd;
  logic        out_valid, busy, done, wrap;
  item_t       sb[$];
  int          checks = 0, errors = 0, done_seen = 0, exp_done = 0;
  bit          stalled = 0;

  bcd_mult11_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count_in(count_in), .abort(abort),
    .out_bcd(out_bcd), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_run(int n);
    int v = 0;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{bcd: to_bcd(v), wrap: (i > 0 && v == 0)});
      v = (v + 11 > 9999) ? 0 : v + 11;
    end
  endtask

  always @(negedge clk) begin
    logic ew;
    if (!rst_n) stalled = 0;
    else if (out_valid) begin
      if (sb.size() == 0) begin
        if (out_ready) chk("extra_beat", out_bcd, 16'hxxxx);
      end else begin
        ew = stalled ? 1'b0 : sb[0].wrap;
        chk("beat_bcd", out_bcd, sb[0].bcd);
        chk("beat_wrap", wrap, ew);
        if (out_ready) begin
          void'(sb.pop_front());
          stalled = 0;
        end else stalled = 1;
      end
    end else begin
      stalled = 0;
      chk("idle_wrap", wrap, 0);
    end
    if (rst_n && done) done_seen++;
  end

  // mode 0: always ready, 1: random ready, 2: hold off 3 cycles on 0022
  task automatic run_counted(int n, int mode);
    int cyc = 0, st = 0;
    push_run(n);
    exp_done++;
    start = 1;
    count_in = 10'(n);
    @(posedge clk); #1 start = 0;
    while (busy && cyc < 20000) begin
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2 && out_valid && out_bcd == 16'h0022 && st < 3) begin
        out_ready = 0;
        st++;
      end else out_ready = 1;
      @(posedge clk); #1;
      cyc++;
    end
    chk("run_timeout", 16'(cyc >= 20000), 0);
    chk("run_all_beats", 16'(sb.size()), 0);
    if (mode == 2) chk("bp_stalls", 16'(st), 3);
    sb.delete();
  endtask

  // free-run until n beats delivered, then abort with the next value presented
  task automatic run_free(int n, bit rnd, bit hold_start);
    int cyc = 0;
    push_run(n);
    start = 1;
    count_in = '0;
    @(posedge clk); #1 if (!hold_start) start = 0;
    while (sb.size() > 0 && cyc < 20000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    chk("free_timeout", 16'(cyc >= 20000), 0);
    out_ready = 0;
    abort = 1;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_bcd", out_bcd, 16'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", wrap, 0);
    #11 rst_n = 1;
    @(posedge clk); #1;
    push_run(4);
    exp_done++;
    out_ready = 1;
    start = 1;
    count_in = 10'd4;
    @(posedge clk); #1 start = 0;
    chk("t2_busy_run", busy, 1);
    chk("t2_first_valid", out_valid, 1);
    repeat (4) @(posedge clk);
    #1 chk("t2_done", done, 1);
    chk("t2_done_novalid", out_valid, 0);
    @(posedge clk); #1 chk("t2_done_pulse", done, 0);
    chk("t2_idle", busy, 0);
    chk("t2_all_beats", 16'(sb.size()), 0);
    run_counted(4, 2);
    run_counted(1, 0);
    run_free(915, 1, 0);
    @(posedge clk); #1 abort = 0;
    chk("t4_abort_valid", out_valid, 0);
    chk("t4_abort_busy", busy, 0);
    run_free(5, 0, 1);
    chk("t5_presented", out_bcd, 16'h0055);
    chk("t5_valid", out_valid, 1);
    @(posedge clk); #1;
    chk("t5_abort_valid", out_valid, 0);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_done", done, 0);
    @(posedge clk); #1 start = 0;
    abort = 0;
    chk("t5_start_abort_idle", busy, 0);
    repeat (8) run_counted($urandom_range(1, 40), 1);
    run_counted(925, 1);
    push_run(4);
    start = 1;
    count_in = 10'd8;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 100 && sb.size() > 0; i++) begin
      out_ready = 1;
      @(posedge clk); #1;
    end
    out_ready = 0;
    chk("t6_presented", out_bcd, 16'h0044);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_bcd", out_bcd, 16'h0000);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_wrap", wrap, 0);
    #3 rst_n = 1;
    @(posedge clk); #1;
    run_counted(3, 0);
    chk("done_count", 16'(done_seen), 16'(exp_done));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
